// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage feeding decode. Owns the fetch PC, issues one
//   outstanding request at a time on a variable-latency req/ack memory port,
//   buffers returned words in a 2-entry FIFO and presents the head to decode
//   with a predecoded type and a 4-bit sequence number.
//
// Parameters
//   RESET_PC    fetch address after reset (low two bits forced to zero)
//   FIFO_DEPTH  buffer entries; only 2 is supported
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cu_wpcir                 decode stall: head is not consumed this cycle
//   cu_branch, id_new_pc     decode redirect: flush FIFO, refetch from target
//   imem_req, imem_addr      fetch request, held stable until imem_ack
//   imem_ack, imem_rdata     response strobe and instruction word
//   if_valid                 FIFO head holds a real instruction
//   if_inst, if_pc4          head word and its address+4 (zero when empty)
//   if_ins_type              predecoded type (zero when empty)
//   if_ins_number            head sequence number (zero when empty)
//
// Optional build
//   IF_PERF_CNT_EN  adds perf_stall_cnt / perf_bubble_cnt saturating counters

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic [31:0] id_new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  if_ins_type,
`ifdef IF_PERF_CNT_EN
    output logic [3:0]  if_ins_number,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt
`else
    output logic [3:0]  if_ins_number
`endif
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [3:0]  ins_type;
        logic [3:0]  num;
    } entry_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] addr_q;
    logic [1:0]  count;
    logic [3:0]  seq;
    entry_t      fifo_q [2];

    logic        pop;
    logic        push;
    logic [1:0]  count_after_pop;
    logic [1:0]  count_next;
    logic [31:0] fetch_pc_plus4;
    entry_t      new_entry;

    // Low address bits of a redirect target are dropped by design.
    logic        unused_pc_lsb;
    assign unused_pc_lsb = ^id_new_pc[1:0];

    function automatic logic [3:0] predecode(input logic [5:0] op);
        case (op)
            6'b000000:            predecode = 4'd1;
            6'b100011:            predecode = 4'd2;
            6'b101011:            predecode = 4'd3;
            6'b000100, 6'b000101: predecode = 4'd4;
            6'b000010, 6'b000011: predecode = 4'd5;
            default:              predecode = 4'd6;
        endcase
    endfunction

    always_comb begin
        pop             = if_valid & ~cu_wpcir & ~cu_branch;
        push            = (state == REQ) & imem_ack & ~cu_branch;
        count_after_pop = count - {1'b0, pop};
        count_next      = count + {1'b0, push} - {1'b0, pop};
        fetch_pc_plus4  = fetch_pc + 32'd4;
        new_entry.inst     = imem_rdata;
        new_entry.pc4      = fetch_pc_plus4;
        new_entry.ins_type = predecode(imem_rdata[31:26]);
        new_entry.num      = seq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            addr_q   <= '0;
            count    <= '0;
            seq      <= '0;
            for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
        end else begin
            if (cu_branch) begin
                count    <= '0;
                fetch_pc <= {id_new_pc[31:2], 2'b00};
            end else begin
                count <= count_next;
                if (push) begin
                    fetch_pc <= fetch_pc_plus4;
                    seq      <= seq + 4'd1;
                end
                // Shift FIFO: slot 0 is always the head. A push never
                // coincides with a full FIFO, so push+pop implies count==1.
                if (pop) begin
                    fifo_q[0] <= push ? new_entry : fifo_q[1];
                end else if (push) begin
                    if (count == 2'd0) fifo_q[0] <= new_entry;
                    else               fifo_q[1] <= new_entry;
                end
            end

            case (state)
                IDLE: begin
                    if (!cu_branch && count_after_pop < FULL) begin
                        state  <= REQ;
                        addr_q <= fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        if (cu_branch) begin
                            state <= IDLE;
                        end else if (count_next < FULL) begin
                            state  <= REQ;
                            addr_q <= fetch_pc_plus4;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cu_branch) begin
                        // Wrong-path request still outstanding: keep the
                        // stale address on the bus until it is acknowledged.
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req      = (state != IDLE);
        imem_addr     = addr_q;
        if_valid      = (count != 2'd0);
        if_inst       = if_valid ? fifo_q[0].inst     : '0;
        if_pc4        = if_valid ? fifo_q[0].pc4      : '0;
        if_ins_type   = if_valid ? fifo_q[0].ins_type : '0;
        if_ins_number = if_valid ? fifo_q[0].num      : '0;
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (if_valid && cu_wpcir && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!if_valid && !cu_branch && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The memory model is either zero-wait
//   (ack follows req combinationally, data from a small address table) or
//   driven by hand for latency / squash scenarios.

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cu_wpcir;
    logic        cu_branch;
    logic [31:0] id_new_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic [3:0]  if_ins_type;
    logic [3:0]  if_ins_number;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    logic        zero_wait;
    logic        ack_man;
    logic [31:0] rdata_man;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0084: mem_word = 32'hAC22_0004;
            32'h0000_0088: mem_word = 32'h1022_0002;
            32'h0000_008C: mem_word = 32'h0800_0010;
            32'h0000_0090: mem_word = 32'h0000_0020;
            default:       mem_word = {6'b001000, a[25:0]};
        endcase
    endfunction

    assign imem_ack   = zero_wait ? imem_req : ack_man;
    assign imem_rdata = zero_wait ? mem_word(imem_addr) : rdata_man;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .cu_wpcir(cu_wpcir), .cu_branch(cu_branch), .id_new_pc(id_new_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
        .if_ins_type(if_ins_type),
`ifdef IF_PERF_CNT_EN
        .if_ins_number(if_ins_number),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`else
        .if_ins_number(if_ins_number)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc4, input logic [3:0] num);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_pc4"}, if_pc4, pc4);
        check({tag, "_num"}, {28'b0, if_ins_number}, {28'b0, num});
    endtask

    task automatic empty(input string tag);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_inst"}, if_inst, 32'd0);
        check({tag, "_pc4"}, if_pc4, 32'd0);
        check({tag, "_type"}, {28'b0, if_ins_type}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cu_wpcir = 1'b0; cu_branch = 1'b0; id_new_pc = '0;
        zero_wait = 1'b1; ack_man = 1'b0; rdata_man = '0;
        tick; tick;
        // Reset state
        empty("rst");
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_num", {28'b0, if_ins_number}, 32'd0);
        rst = 1'b0;

        // Zero-wait streaming from address 0
        tick;                                   // edge 1: IDLE -> REQ
        check("e1_req", {31'b0, imem_req}, 32'd1);
        check("e1_addr", imem_addr, 32'h0);
        check("e1_valid", {31'b0, if_valid}, 32'd0);
        tick;                                   // edge 2: first push
        head("e2", 32'h4, 4'd0);
        check("e2_inst", if_inst, 32'h2000_0000);
        check("e2_type", {28'b0, if_ins_type}, 32'd6);
        check("e2_addr", imem_addr, 32'h4);
        tick;                                   // edge 3
        head("e3", 32'h8, 4'd1);

        // Decode stall for three cycles with head pc4=8
        cu_wpcir = 1'b1;
        tick;                                   // edge 4: FIFO fills
        head("e4", 32'h8, 4'd1);
        check("e4_req", {31'b0, imem_req}, 32'd0);
        tick;
        head("e5", 32'h8, 4'd1);
        check("e5_req", {31'b0, imem_req}, 32'd0);
        tick;
        head("e6", 32'h8, 4'd1);
        check("e6_req", {31'b0, imem_req}, 32'd0);
        check("e6_inst", if_inst, 32'h2000_0004);
        cu_wpcir = 1'b0;
        tick;                                   // edge 7: pop, resume fetch
        head("e7", 32'hC, 4'd2);
        check("e7_req", {31'b0, imem_req}, 32'd1);
        check("e7_addr", imem_addr, 32'hC);
        tick;
        head("e8", 32'h10, 4'd3);

        // Redirect with zero-wait memory (low target bits ignored)
        cu_branch = 1'b1; id_new_pc = 32'h0000_0041;
        tick;                                   // edge 9: flush
        empty("e9");
        check("e9_req", {31'b0, imem_req}, 32'd0);
        cu_branch = 1'b0; id_new_pc = '0;
        tick;
        check("e10_req", {31'b0, imem_req}, 32'd1);
        check("e10_addr", imem_addr, 32'h40);
        tick;
        head("e11", 32'h44, 4'd4);
        check("e11_inst", if_inst, 32'h2000_0040);

        // Slow memory, redirect while a request is outstanding
        zero_wait = 1'b0; ack_man = 1'b0;
        tick;                                   // edge 12: head popped, no ack
        check("e12_valid", {31'b0, if_valid}, 32'd0);
        check("e12_addr", imem_addr, 32'h44);
        cu_branch = 1'b1; id_new_pc = 32'h0000_0080;
        tick;                                   // edge 13: REQ -> DROP
        check("e13_req", {31'b0, imem_req}, 32'd1);
        check("e13_addr", imem_addr, 32'h44);
        cu_branch = 1'b0; id_new_pc = '0;
        tick;
        check("e14_req", {31'b0, imem_req}, 32'd1);
        check("e14_addr", imem_addr, 32'h44);
        ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
        tick;                                   // edge 15: stale ack discarded
        check("e15_valid", {31'b0, if_valid}, 32'd0);
        check("e15_req", {31'b0, imem_req}, 32'd0);
        tick;                                   // edge 16: ack while IDLE ignored
        check("e16_valid", {31'b0, if_valid}, 32'd0);
        check("e16_req", {31'b0, imem_req}, 32'd1);
        check("e16_addr", imem_addr, 32'h80);
        ack_man = 1'b0;
        tick;
        check("e17_valid", {31'b0, if_valid}, 32'd0);
        ack_man = 1'b1; rdata_man = 32'h8C22_0004;
        tick;                                   // edge 18: load word arrives
        head("e18", 32'h84, 4'd5);
        check("e18_inst", if_inst, 32'h8C22_0004);
        check("e18_type", {28'b0, if_ins_type}, 32'd2);
        check("e18_addr", imem_addr, 32'h84);

        // Predecode types and sequence wrap
        ack_man = 1'b0; zero_wait = 1'b1;
        tick;
        head("e19", 32'h88, 4'd6);
        check("e19_type", {28'b0, if_ins_type}, 32'd3);
        tick;
        head("e20", 32'h8C, 4'd7);
        check("e20_type", {28'b0, if_ins_type}, 32'd4);
        tick;
        head("e21", 32'h90, 4'd8);
        check("e21_type", {28'b0, if_ins_type}, 32'd5);
        tick;
        head("e22", 32'h94, 4'd9);
        check("e22_type", {28'b0, if_ins_type}, 32'd1);
        repeat (6) tick;
        head("e28", 32'hAC, 4'd15);
        tick;
        head("e29", 32'hB0, 4'd0);

        // Address wrap at the top of memory
        cu_branch = 1'b1; id_new_pc = 32'hFFFF_FFFF;
        tick;
        empty("e30");
        cu_branch = 1'b0; id_new_pc = '0;
        tick;
        check("e31_addr", imem_addr, 32'hFFFF_FFFC);
        tick;
        head("e32", 32'h0, 4'd1);
        check("e32_inst", if_inst, 32'h23FF_FFFC);
        check("e32_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a request
        zero_wait = 1'b0; ack_man = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_valid", {31'b0, if_valid}, 32'd0);
        check("arst_addr", imem_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("arst_stall", perf_stall_cnt, 32'd0);
        check("arst_bubble", perf_bubble_cnt, 32'd0);
`endif
        tick;
        rst = 1'b0; ack_man = 1'b1; rdata_man = 32'h0000_1234;
        tick;                                   // late ack in IDLE ignored
        check("r1_valid", {31'b0, if_valid}, 32'd0);
        check("r1_req", {31'b0, imem_req}, 32'd1);
        check("r1_addr", imem_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("r1_bubble", perf_bubble_cnt, 32'd1);
`endif
        tick;
        head("r2", 32'h4, 4'd0);
        check("r2_inst", if_inst, 32'h0000_1234);
        check("r2_type", {28'b0, if_ins_type}, 32'd1);
        ack_man = 1'b0; cu_wpcir = 1'b1;
        tick; tick;
        head("r4", 32'h4, 4'd0);
`ifdef IF_PERF_CNT_EN
        check("r4_stall", perf_stall_cnt, 32'd2);
        check("r4_bubble", perf_bubble_cnt, 32'd2);
`endif
        cu_wpcir = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
